// File: rtl/fir_requant_pkg.sv
// rtl/fir_requant_pkg.sv - shared packet-tracking state encoding and counter width for the requantizer
package fir_requant_pkg;

    localparam int SAT_COUNT_W = 16;

    // Packet-tracking state enumeration (IDLE / IN_PKT)
    typedef logic [0:0] pkt_state_t;
    localparam pkt_state_t ST_IDLE   = 1'b0;
    localparam pkt_state_t ST_IN_PKT = 1'b1;

endpackage

// File: rtl/axis_fir_requant_if.sv
// rtl/axis_fir_requant_if.sv - stream bundle (data, strobe, valid, ready, last) with master/slave views
interface axis_fir_requant_if #(
    parameter int W = 8
);
    logic [W-1:0]     tdata;
    logic [W/8-1:0]   tstrb;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, tstrb, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/requant_sat.sv
// rtl/requant_sat.sv - clip a wide signed value to OUT_W bits, optionally offset-binary
module requant_sat #(
    parameter int IN_W  = 65,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  din_i,
    input  logic                    offset_mode_i,
    output logic [OUT_W-1:0]        dout_o,
    output logic                    clipped_o
);
    localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] SAT_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [OUT_W-1:0] twos;

    always_comb begin
        twos      = din_i[OUT_W-1:0];
        clipped_o = 1'b0;
        if (din_i > SAT_MAX) begin
            twos      = {1'b0, {(OUT_W-1){1'b1}}};
            clipped_o = 1'b1;
        end else if (din_i < SAT_MIN) begin
            twos      = {1'b1, {(OUT_W-1){1'b0}}};
            clipped_o = 1'b1;
        end
    end

    // Offset-binary is two's complement with the sign bit flipped
    assign dout_o = offset_mode_i ? {~twos[OUT_W-1], twos[OUT_W-2:0]} : twos;
endmodule

// File: rtl/axis_fir_requant.sv
// rtl/axis_fir_requant.sv - round/shift/saturate a wide FIR accumulator stream into DAC-width samples
module axis_fir_requant
    import fir_requant_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int C_M00_AXIS_TDATA_WIDTH = 8,
    parameter int BASE_SHIFT             = 24,
    parameter int SHIFT_WIDTH            = 4
) (
    input  logic                                     s00_axis_aclk,
    input  logic                                     s00_axis_aresetn,
    input  logic signed [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                                     s00_axis_tvalid,
    input  logic                                     s00_axis_tlast,
    output logic                                     s00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]        m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]      m00_axis_tstrb,
    output logic                                     m00_axis_tvalid,
    output logic                                     m00_axis_tlast,
    input  logic                                     m00_axis_tready,
    input  logic [SHIFT_WIDTH-1:0]                   shift,
    input  logic                                     offset_mode,
    input  logic                                     sat_clear,
    output logic [SAT_COUNT_W-1:0]                   sat_count
);
    localparam int IW = C_S00_AXIS_TDATA_WIDTH;
    localparam int OW = C_M00_AXIS_TDATA_WIDTH;
    localparam int EW = $clog2(IW) + 1;
    localparam logic signed [IW:0] ONE = 1;

    logic                   en, s_fire, in_pkt;
    pkt_state_t             state_q, state_d;
    logic [SHIFT_WIDTH-1:0] shift_active_q, shift_active_d, shift_sel;
    logic                   offset_active_q, offset_active_d, om_sel;
    logic [EW-1:0]          eff_shift;
    logic signed [IW:0]     din_ext, round_add, rounded, shifted;

    logic                   s1_valid_q, s1_last_q, s1_om_q;
    logic signed [IW:0]     s1_data_q;
    logic                   s2_valid_q, s2_last_q;
    logic [OW-1:0]          s2_data_q, sat_dout;
    logic                   sat_clipped;
    logic [SAT_COUNT_W-1:0] sat_count_q, sat_count_d;

    assign en              = m00_axis_tready | ~s2_valid_q;
    assign s00_axis_tready = en;
    assign s_fire          = s00_axis_tvalid & en;
    assign in_pkt          = (state_q == ST_IN_PKT);

    // Gain and output format are frozen for the duration of a packet
    assign shift_sel = in_pkt ? shift_active_q  : shift;
    assign om_sel    = in_pkt ? offset_active_q : offset_mode;
    assign eff_shift = EW'(shift_sel) + EW'(BASE_SHIFT);

    always_comb begin
        din_ext   = {s00_axis_tdata[IW-1], s00_axis_tdata};
        round_add = '0;
        if (eff_shift != '0) round_add = ONE << (eff_shift - 1'b1);
        rounded   = din_ext + round_add;
        shifted   = rounded >>> eff_shift;
    end

    always_comb begin
        state_d         = state_q;
        shift_active_d  = shift_active_q;
        offset_active_d = offset_active_q;
        if (s_fire) begin
            state_d = s00_axis_tlast ? ST_IDLE : ST_IN_PKT;
            if (!in_pkt) begin
                shift_active_d  = shift;
                offset_active_d = offset_mode;
            end
        end
    end

    requant_sat #(.IN_W(IW + 1), .OUT_W(OW)) u_sat (
        .din_i         (s1_data_q),
        .offset_mode_i (s1_om_q),
        .dout_o        (sat_dout),
        .clipped_o     (sat_clipped)
    );

    always_comb begin
        sat_count_d = sat_clear ? '0 : sat_count_q;
        if (en && s1_valid_q && sat_clipped && (sat_count_d != '1))
            sat_count_d = sat_count_d + 1'b1;
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q         <= ST_IDLE;
            shift_active_q  <= '0;
            offset_active_q <= 1'b0;
            s1_valid_q      <= 1'b0;
            s1_last_q       <= 1'b0;
            s1_om_q         <= 1'b0;
            s1_data_q       <= '0;
            s2_valid_q      <= 1'b0;
            s2_last_q       <= 1'b0;
            s2_data_q       <= '0;
            sat_count_q     <= '0;
        end else begin
            state_q         <= state_d;
            shift_active_q  <= shift_active_d;
            offset_active_q <= offset_active_d;
            sat_count_q     <= sat_count_d;
            if (en) begin
                s1_valid_q <= s00_axis_tvalid;
                s2_valid_q <= s1_valid_q;
                if (s_fire) begin
                    s1_data_q <= shifted;
                    s1_last_q <= s00_axis_tlast;
                    s1_om_q   <= om_sel;
                end
                if (s1_valid_q) begin
                    s2_data_q <= sat_dout;
                    s2_last_q <= s1_last_q;
                end
            end
        end
    end

    assign m00_axis_tdata  = s2_data_q;
    assign m00_axis_tlast  = s2_last_q;
    assign m00_axis_tvalid = s2_valid_q;
    assign m00_axis_tstrb  = '1;
    assign sat_count       = sat_count_q;
endmodule

// File: tb/tb_axis_fir_requant.sv
// tb/tb_axis_fir_requant.sv - directed vector bench for axis_fir_requant
module tb_axis_fir_requant;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  shift;
    logic        offset_mode;
    logic        sat_clear;
    logic [15:0] sat_count;

    always #5 clk = ~clk;

    axis_fir_requant_if #(.W(64)) s_if ();
    axis_fir_requant_if #(.W(8))  m_if ();

    axis_fir_requant dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tdata   (s_if.tdata),
        .s00_axis_tvalid  (s_if.tvalid),
        .s00_axis_tlast   (s_if.tlast),
        .s00_axis_tready  (s_if.tready),
        .m00_axis_tdata   (m_if.tdata),
        .m00_axis_tstrb   (m_if.tstrb),
        .m00_axis_tvalid  (m_if.tvalid),
        .m00_axis_tlast   (m_if.tlast),
        .m00_axis_tready  (m_if.tready),
        .shift            (shift),
        .offset_mode      (offset_mode),
        .sat_clear        (sat_clear),
        .sat_count        (sat_count)
    );

    typedef struct {
        logic [63:0] din;
        logic [3:0]  sh;
        logic        om;
        logic [7:0]  exp;
        logic        clip;
    } vec_t;

    vec_t        vecs[12];
    int          total = 0;
    int          bad = 0;
    int          exp_cnt;

    logic [63:0] st_din[8];
    logic        st_last[8];
    logic [3:0]  st_sh[8];
    logic        st_om[8];
    int          st_n, st_stall_lo, st_stall_hi;
    logic [8:0]  got[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic run_stream();
        int         idx;
        logic       prev_hold;
        logic [8:0] prev_out;
        logic       s_fire;
        idx = 0;
        prev_hold = 1'b0;
        prev_out = '0;
        got.delete();
        for (int cyc = 0; cyc < 60 && got.size() < st_n; cyc++) begin
            m_if.tready = !(cyc >= st_stall_lo && cyc < st_stall_hi);
            if (idx < st_n) begin
                s_if.tdata  = st_din[idx];
                s_if.tlast  = st_last[idx];
                shift       = st_sh[idx];
                offset_mode = st_om[idx];
                s_if.tvalid = 1'b1;
            end else begin
                s_if.tvalid = 1'b0;
            end
            #3;
            if (prev_hold) begin
                chk("hold_data", {55'd0, m_if.tlast, m_if.tdata}, {55'd0, prev_out});
                chk("hold_valid", {63'd0, m_if.tvalid}, 64'd1);
            end
            if (m_if.tvalid && !m_if.tready) chk("stall_s_tready", {63'd0, s_if.tready}, 64'd0);
            if (m_if.tvalid && m_if.tready) got.push_back({m_if.tlast, m_if.tdata});
            prev_hold = m_if.tvalid && !m_if.tready;
            prev_out  = {m_if.tlast, m_if.tdata};
            s_fire    = s_if.tvalid && s_if.tready;
            @(posedge clk); #1;
            if (s_fire) idx++;
        end
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        chk("stream_count", 64'(got.size()), 64'(st_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{64'sd0,                              4'd0,  1'b1, 8'd128, 1'b0};
        vecs[1]  = '{64'sd127 << 24,                      4'd0,  1'b1, 8'd255, 1'b0};
        vecs[2]  = '{-(64'sd128 << 24),                   4'd0,  1'b1, 8'd0,   1'b0};
        vecs[3]  = '{64'sd1 << 23,                        4'd0,  1'b1, 8'd129, 1'b0};
        vecs[4]  = '{(64'sd1 << 23) - 64'sd1,             4'd0,  1'b1, 8'd128, 1'b0};
        vecs[5]  = '{-(64'sd1 << 24),                     4'd0,  1'b0, 8'hFF,  1'b0};
        vecs[6]  = '{64'sd200 << 24,                      4'd0,  1'b1, 8'd255, 1'b1};
        vecs[7]  = '{-(64'sd200 << 24),                   4'd0,  1'b1, 8'd0,   1'b1};
        vecs[8]  = '{-(64'sd1 << 23) - 64'sd1,            4'd0,  1'b1, 8'd127, 1'b0};
        vecs[9]  = '{64'sd16 << 24,                       4'd4,  1'b1, 8'd129, 1'b0};
        vecs[10] = '{64'sd5 << 39,                        4'd15, 1'b0, 8'h05,  1'b0};
        vecs[11] = '{(64'sd127 << 24) + (64'sd1 << 23),   4'd0,  1'b1, 8'd255, 1'b1};

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tstrb  = '1;
        m_if.tready = 1'b1;
        shift       = '0;
        offset_mode = 1'b1;
        sat_clear   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", {63'd0, m_if.tvalid}, 64'd0);
        chk("rst_m_tdata", {56'd0, m_if.tdata}, 64'd0);
        chk("rst_m_tlast", {63'd0, m_if.tlast}, 64'd0);
        chk("rst_sat_count", {48'd0, sat_count}, 64'd0);
        chk("rst_tstrb", {63'd0, m_if.tstrb}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rel_s_tready", {63'd0, s_if.tready}, 64'd1);
        @(posedge clk); #1;

        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            shift       = vecs[i].sh;
            offset_mode = vecs[i].om;
            s_if.tdata  = vecs[i].din;
            s_if.tlast  = 1'b1;
            s_if.tvalid = 1'b1;
            @(posedge clk); #1;
            s_if.tvalid = 1'b0;
            chk($sformatf("vec%0d_early_valid", i), {63'd0, m_if.tvalid}, 64'd0);
            @(posedge clk); #1;
            if (vecs[i].clip) exp_cnt++;
            chk($sformatf("vec%0d_valid", i), {63'd0, m_if.tvalid}, 64'd1);
            chk($sformatf("vec%0d_data", i), {56'd0, m_if.tdata}, {56'd0, vecs[i].exp});
            chk($sformatf("vec%0d_last", i), {63'd0, m_if.tlast}, 64'd1);
            chk($sformatf("vec%0d_sat_count", i), {48'd0, sat_count}, 64'(exp_cnt));
        end

        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        chk("sat_clear", {48'd0, sat_count}, 64'd0);

        shift = 4'd0; offset_mode = 1'b1;
        s_if.tdata = 64'sd200 << 24; s_if.tlast = 1'b1; s_if.tvalid = 1'b1;
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        chk("clear_and_inc", {48'd0, sat_count}, 64'd1);
        chk("clear_and_inc_data", {56'd0, m_if.tdata}, 64'd255);
        @(posedge clk); #1;

        st_n = 8; st_stall_lo = 5; st_stall_hi = 8;
        for (int i = 0; i < 8; i++) begin
            st_din[i] = 64'(i + 1) << 24; st_last[i] = (i == 7);
            st_sh[i] = 4'd0; st_om[i] = 1'b1;
        end
        run_stream();
        for (int i = 0; i < 8; i++)
            if (i < got.size())
                chk($sformatf("stall_beat%0d", i), {55'd0, got[i]}, {55'd0, (i == 7), 8'(129 + i)});

        st_n = 5; st_stall_lo = 100; st_stall_hi = 100;
        for (int i = 0; i < 5; i++) begin
            st_din[i] = 64'sd16 << 24; st_last[i] = (i >= 3);
            st_sh[i] = (i == 0) ? 4'd0 : 4'd4; st_om[i] = (i == 1 || i == 2 || i == 3) ? 1'b0 : 1'b1;
        end
        run_stream();
        for (int i = 0; i < 5; i++)
            if (i < got.size())
                chk($sformatf("pkt_beat%0d", i), {55'd0, got[i]},
                    {55'd0, (i >= 3), (i == 4) ? 8'd129 : 8'd144});

        shift = 4'd4; offset_mode = 1'b1;
        s_if.tdata = 64'sd4000 << 24; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
        @(posedge clk); #1;
        s_if.tdata = 64'sd200 << 24;
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        chk("inflight_valid", {63'd0, m_if.tvalid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, m_if.tvalid}, 64'd0);
        chk("async_rst_sat_count", {48'd0, sat_count}, 64'd0);
        chk("async_rst_tdata", {56'd0, m_if.tdata}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_s_tready", {63'd0, s_if.tready}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("no_stale_%0d", i), {63'd0, m_if.tvalid}, 64'd0);
        end
        shift = 4'd4;
        s_if.tdata = 64'sd16 << 24; s_if.tlast = 1'b1; s_if.tvalid = 1'b1;
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_valid", {63'd0, m_if.tvalid}, 64'd1);
        chk("post_rst_fsm_idle", {56'd0, m_if.tdata}, 64'd129);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
